// File: rtl/fir_out_fifo_if.sv
// Producer/consumer bundle for the FIR output FIFO.
// The FIFO takes the slave side; the environment takes master.
interface fir_out_fifo_if #(
    parameter int DATA_W = 7,
    parameter int INT_W  = 3,
    parameter int DEPTH  = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                     i_sample_en;
    logic signed [DATA_W-1:0] Yin;
    logic                     i_ready;
    logic                     i_clr_ovf;
    logic                     o_valid;
    logic signed [DATA_W-1:0] o_raw;
    logic signed [INT_W-1:0]  o_int;
    logic                     o_sat;
    logic [CW-1:0]            o_count;
    logic                     o_full;
    logic                     o_ovf;

    modport master (
        output i_sample_en, Yin, i_ready, i_clr_ovf,
        input  o_valid, o_raw, o_int, o_sat, o_count, o_full, o_ovf
    );

    modport slave (
        input  i_sample_en, Yin, i_ready, i_clr_ovf,
        output o_valid, o_raw, o_int, o_sat, o_count, o_full, o_ovf
    );
endinterface

// File: rtl/fir_out_fifo.sv
// FWFT FIFO after the 3-tap FIR: stores raw Q4 result plus a
// round-half-up, saturated integer; sticky overflow on drop.
module fir_out_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 7,
    parameter int FRAC_W = 4,
    parameter int INT_W  = 3
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    fir_out_fifo_if.slave bus
);
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int EW  = 1 + INT_W + DATA_W;
    localparam int SW  = DATA_W + 1;

    localparam logic signed [SW-1:0] HALF  = SW'(2 ** (FRAC_W - 1));
    localparam logic signed [SW-1:0] MAX_Q = SW'(2 ** (INT_W - 1) - 1);
    localparam logic signed [SW-1:0] MIN_Q = SW'(-(2 ** (INT_W - 1)));

    logic [EW-1:0]           mem [DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [CW-1:0]           count;
    logic [CW-1:0]           count_nxt;
    logic                    full;
    logic                    ovf;

    logic signed [SW-1:0]    sum;
    logic signed [SW-1:0]    q;
    logic signed [INT_W-1:0] rint;
    logic                    rsat;

    logic                    valid;
    logic                    push;
    logic                    pop;
    logic                    drop;
    logic [EW-1:0]           head;

    always_comb begin
        sum  = {bus.Yin[DATA_W-1], bus.Yin} + HALF;
        q    = sum >>> FRAC_W;
        rint = q[INT_W-1:0];
        rsat = 1'b0;
        if (q > MAX_Q) begin
            rint = MAX_Q[INT_W-1:0];
            rsat = 1'b1;
        end else if (q < MIN_Q) begin
            rint = MIN_Q[INT_W-1:0];
            rsat = 1'b1;
        end
    end

    assign valid = (count != '0);
    assign pop   = valid && bus.i_ready;
    assign push  = bus.i_sample_en && (!full || pop);
    assign drop  = bus.i_sample_en && full && !pop;

    always_comb begin
        count_nxt = count;
        unique case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            ovf    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {rsat, rint, bus.Yin};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            // a drop in the same cycle as a clear keeps the flag set
            if (drop)               ovf <= 1'b1;
            else if (bus.i_clr_ovf) ovf <= 1'b0;
        end
    end

    assign head        = mem[rd_ptr];
    assign bus.o_valid = valid;
    assign bus.o_raw   = head[DATA_W-1:0];
    assign bus.o_int   = head[DATA_W+INT_W-1:DATA_W];
    assign bus.o_sat   = head[EW-1];
    assign bus.o_count = count;
    assign bus.o_full  = full;
    assign bus.o_ovf   = ovf;
endmodule
